// File: rtl/cve2_pkg.sv
// Shared types for the core sleep controller: FSM state encoding and
// the helper that sizes the hysteresis counters.
package cve2_pkg;

   typedef enum logic [2:0] {
      SLP_DISABLED = 3'd0,
      SLP_RUN      = 3'd1,
      SLP_IDLE     = 3'd2,
      SLP_SLEEP    = 3'd3,
      SLP_WAKE     = 3'd4
   } sleep_state_e;

   // A delay of N needs a counter reaching N-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned delay);
      return (delay > 32'd1) ? $clog2(delay) : 32'd1;
   endfunction

endpackage

// File: rtl/cve2_clock_gate.sv
// Latch-based glitch-free clock gate; the enable is captured while the
// clock is low so clk_o only ever produces whole high phases.
module cve2_clock_gate (
   input  logic clk_i,
   input  logic en_i,
   input  logic scan_cg_en_i,
   output logic clk_o
);

   logic r_en_latch;

   // Enable latch, transparent during the low phase of clk_i.
   always_latch begin
      if (!clk_i) begin
         r_en_latch <= en_i | scan_cg_en_i;
      end
   end

   assign clk_o = clk_i & r_en_latch;

endmodule

// File: rtl/cve2_sleep_ctrl.sv
// Core clock-enable / sleep controller: sticky fetch enable, idle hysteresis
// before gating, maskable + unmaskable wake with clock-settle delay.
module cve2_sleep_ctrl
   import cve2_pkg::*;
#(
   parameter int unsigned NumWakeSrc = 4,
   parameter int unsigned IdleDelay  = 2,
   parameter int unsigned WakeDelay  = 1,
   parameter int unsigned CntW       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  test_en_i,
   input  logic                  fetch_enable_i,
   input  logic                  core_busy_i,
   input  logic [NumWakeSrc-1:0] wake_src_i,
   input  logic [NumWakeSrc-1:0] wake_mask_i,
   input  logic                  wake_nmi_i,
   input  logic                  debug_req_i,
   output logic                  clk_o,
   output logic                  clock_en_o,
   output logic                  fetch_enable_o,
   output logic                  core_sleep_o,
   output logic [NumWakeSrc+1:0] wake_cause_o,
   output logic [CntW-1:0]       sleep_cnt_o
);

   localparam int unsigned IdleCntW = cnt_width(IdleDelay);
   localparam int unsigned WakeCntW = cnt_width(WakeDelay);
   localparam logic [IdleCntW-1:0] IdleLast =
      IdleCntW'((IdleDelay > 32'd0) ? (IdleDelay - 32'd1) : 32'd0);
   localparam logic [WakeCntW-1:0] WakeLast =
      WakeCntW'((WakeDelay > 32'd0) ? (WakeDelay - 32'd1) : 32'd0);

   sleep_state_e          r_state;
   logic                  r_fetch_en;
   logic                  r_clock_en;
   logic                  r_core_sleep;
   logic [NumWakeSrc+1:0] r_wake_cause;
   logic [CntW-1:0]       r_sleep_cnt;
   logic [IdleCntW-1:0]   r_idle_cnt;
   logic [WakeCntW-1:0]   r_wake_cnt;

   logic [NumWakeSrc-1:0] w_wake_masked;
   logic                  w_wake_any;
   logic                  w_cnt_sat;

   assign w_wake_masked = wake_src_i & wake_mask_i;
   assign w_wake_any    = (|w_wake_masked) | wake_nmi_i | debug_req_i;
   assign w_cnt_sat     = (r_sleep_cnt == {CntW{1'b1}});

   // Sleep FSM; clock_en / core_sleep are registered alongside the state so
   // they are clean decodes with no input-to-output combinational path.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= SLP_DISABLED;
         r_fetch_en   <= 1'b0;
         r_clock_en   <= 1'b0;
         r_core_sleep <= 1'b0;
         r_wake_cause <= '0;
         r_sleep_cnt  <= '0;
         r_idle_cnt   <= '0;
         r_wake_cnt   <= '0;
      end else begin
         if (fetch_enable_i) begin
            r_fetch_en <= 1'b1;
         end
         case (r_state)
            SLP_DISABLED: begin
               if (r_fetch_en) begin
                  r_state    <= SLP_RUN;
                  r_clock_en <= 1'b1;
               end
            end
            SLP_RUN: begin
               if (!core_busy_i && !w_wake_any) begin
                  if (IdleDelay == 32'd0) begin
                     r_state      <= SLP_SLEEP;
                     r_clock_en   <= 1'b0;
                     r_core_sleep <= 1'b1;
                     if (!w_cnt_sat) begin
                        r_sleep_cnt <= r_sleep_cnt + CntW'(1);
                     end
                  end else begin
                     r_state    <= SLP_IDLE;
                     r_idle_cnt <= '0;
                  end
               end
            end
            SLP_IDLE: begin
               // Busy or wake on the same cycle as the final idle count wins.
               if (core_busy_i || w_wake_any) begin
                  r_state <= SLP_RUN;
               end else if (r_idle_cnt == IdleLast) begin
                  r_state      <= SLP_SLEEP;
                  r_clock_en   <= 1'b0;
                  r_core_sleep <= 1'b1;
                  if (!w_cnt_sat) begin
                     r_sleep_cnt <= r_sleep_cnt + CntW'(1);
                  end
               end else begin
                  r_idle_cnt <= r_idle_cnt + IdleCntW'(1);
               end
            end
            SLP_SLEEP: begin
               if (w_wake_any) begin
                  r_wake_cause <= {debug_req_i, wake_nmi_i, w_wake_masked};
                  r_core_sleep <= 1'b0;
                  if (WakeDelay == 32'd0) begin
                     r_state    <= SLP_RUN;
                     r_clock_en <= 1'b1;
                  end else begin
                     r_state    <= SLP_WAKE;
                     r_wake_cnt <= '0;
                  end
               end
            end
            SLP_WAKE: begin
               // Once started, a wake always completes even if the source drops.
               if (r_wake_cnt == WakeLast) begin
                  r_state    <= SLP_RUN;
                  r_clock_en <= 1'b1;
               end else begin
                  r_wake_cnt <= r_wake_cnt + WakeCntW'(1);
               end
            end
            default: begin
               r_state      <= SLP_DISABLED;
               r_clock_en   <= 1'b0;
               r_core_sleep <= 1'b0;
            end
         endcase
      end
   end

   cve2_clock_gate u_clock_gate (
      .clk_i        (clk_i),
      .en_i         (r_clock_en),
      .scan_cg_en_i (test_en_i),
      .clk_o        (clk_o)
   );

   assign clock_en_o     = r_clock_en;
   assign fetch_enable_o = r_fetch_en;
   assign core_sleep_o   = r_core_sleep;
   assign wake_cause_o   = r_wake_cause;
   assign sleep_cnt_o    = r_sleep_cnt;

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// Self-checking bench for cve2_sleep_ctrl: per-cycle vector table through a
// scoreboard queue, then hand-written latency and clock-gating sequences.
module tb_cve2_sleep_ctrl;

   logic       clk = 1'b0;
   logic       rst, test_en, fetch, busy, nmi, dbg;
   logic [3:0] src, mask;
   logic       clk_o, clock_en_o, fetch_enable_o, core_sleep_o;
   logic [5:0] wake_cause_o;
   logic [1:0] sleep_cnt_o;

   int n_checks = 0;
   int n_errors = 0;
   int clko_edges = 0;

   always #5 clk = ~clk;
   always @(posedge clk_o) clko_edges <= clko_edges + 1;

   cve2_sleep_ctrl #(
      .NumWakeSrc(4), .IdleDelay(2), .WakeDelay(1), .CntW(2)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .test_en_i      (test_en),
      .fetch_enable_i (fetch),
      .core_busy_i    (busy),
      .wake_src_i     (src),
      .wake_mask_i    (mask),
      .wake_nmi_i     (nmi),
      .debug_req_i    (dbg),
      .clk_o          (clk_o),
      .clock_en_o     (clock_en_o),
      .fetch_enable_o (fetch_enable_o),
      .core_sleep_o   (core_sleep_o),
      .wake_cause_o   (wake_cause_o),
      .sleep_cnt_o    (sleep_cnt_o)
   );

   typedef struct packed {
      logic       rst, fetch, busy;
      logic [3:0] src, mask;
      logic       nmi, dbg;
      logic       fe, ce, sl;
      logic [5:0] cause;
      logic [1:0] cnt;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   function automatic vec_t mk(logic r, logic f, logic b, logic [3:0] s, logic [3:0] m,
                               logic n, logic d, logic efe, logic ece, logic esl,
                               logic [5:0] ecause, logic [1:0] ecnt);
      vec_t v;
      v = '{r, f, b, s, m, n, d, efe, ece, esl, ecause, ecnt};
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst   = v.rst;
      fetch = v.fetch;
      busy  = v.busy;
      src   = v.src;
      mask  = v.mask;
      nmi   = v.nmi;
      dbg   = v.dbg;
   endtask

   int base;
   int n;
   vec_t e;

   initial begin
      rst = 1'b1; test_en = 1'b0; fetch = 1'b0; busy = 1'b0;
      src = 4'd0; mask = 4'd0; nmi = 1'b0; dbg = 1'b0;

      //            rst fe  bsy src    mask   nmi dbg | fe  ce  sl  cause     cnt
      vecs.push_back(mk(1,0,0,4'h0,4'h0,0,0, 0,0,0,6'h00,2'd0));
      vecs.push_back(mk(1,0,0,4'h0,4'h0,0,0, 0,0,0,6'h00,2'd0));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 0,0,0,6'h00,2'd0));
      vecs.push_back(mk(0,1,1,4'h0,4'h0,0,0, 1,0,0,6'h00,2'd0)); // fetch pulse
      vecs.push_back(mk(0,0,1,4'h0,4'h0,0,0, 1,1,0,6'h00,2'd0));
      vecs.push_back(mk(0,0,1,4'h0,4'h0,0,0, 1,1,0,6'h00,2'd0));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h00,2'd0)); // busy drop -> IDLE
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h00,2'd0));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,0,1,6'h00,2'd1)); // SLEEP
      vecs.push_back(mk(0,0,0,4'h2,4'hD,0,0, 1,0,1,6'h00,2'd1)); // masked out
      vecs.push_back(mk(0,0,0,4'h2,4'h2,0,0, 1,0,0,6'h02,2'd1)); // WAKE
      vecs.push_back(mk(0,0,1,4'h0,4'h2,0,0, 1,1,0,6'h02,2'd1)); // RUN, src dropped
      vecs.push_back(mk(0,0,1,4'h0,4'h0,0,0, 1,1,0,6'h02,2'd1));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h02,2'd1)); // IDLE
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h02,2'd1));
      vecs.push_back(mk(0,0,1,4'h0,4'h0,0,0, 1,1,0,6'h02,2'd1)); // busy at idle_cnt=1
      vecs.push_back(mk(0,0,1,4'h0,4'h0,0,0, 1,1,0,6'h02,2'd1));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h02,2'd1)); // IDLE
      vecs.push_back(mk(0,0,0,4'h1,4'h1,0,0, 1,1,0,6'h02,2'd1)); // wake beats idle
      vecs.push_back(mk(0,0,1,4'h0,4'h0,0,0, 1,1,0,6'h02,2'd1));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,1,0, 1,1,0,6'h02,2'd1)); // nmi holds RUN
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h02,2'd1));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h02,2'd1));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,0,1,6'h02,2'd2)); // sleep #2
      vecs.push_back(mk(0,0,0,4'h0,4'h0,1,1, 1,0,0,6'h30,2'd2)); // nmi+debug
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h30,2'd2));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h30,2'd2));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h30,2'd2));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,0,1,6'h30,2'd3)); // sleep #3
      vecs.push_back(mk(0,0,0,4'h1,4'h1,0,0, 1,0,0,6'h01,2'd3));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h01,2'd3));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h01,2'd3));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h01,2'd3));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,0,1,6'h01,2'd3)); // sleep #4 saturated
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,1, 1,0,0,6'h20,2'd3));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h20,2'd3));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h20,2'd3));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,1,0,6'h20,2'd3));
      vecs.push_back(mk(0,0,0,4'h0,4'h0,0,0, 1,0,1,6'h20,2'd3)); // sleep #5
      vecs.push_back(mk(0,0,0,4'h0,4'h0,1,0, 1,0,0,6'h10,2'd3)); // WAKE
      vecs.push_back(mk(1,0,0,4'h0,4'h0,0,0, 0,0,0,6'h00,2'd0)); // reset in WAKE
      vecs.push_back(mk(0,0,1,4'h0,4'h0,0,0, 0,0,0,6'h00,2'd0));
      vecs.push_back(mk(0,0,1,4'h0,4'h0,0,0, 0,0,0,6'h00,2'd0));
      vecs.push_back(mk(0,1,1,4'h0,4'h0,0,0, 1,0,0,6'h00,2'd0)); // re-request
      vecs.push_back(mk(0,0,1,4'h0,4'h0,0,0, 1,1,0,6'h00,2'd0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk("fetch_enable_o", i, 32'(fetch_enable_o), 32'(e.fe));
         chk("clock_en_o",     i, 32'(clock_en_o),     32'(e.ce));
         chk("core_sleep_o",   i, 32'(core_sleep_o),   32'(e.sl));
         chk("wake_cause_o",   i, 32'(wake_cause_o),   32'(e.cause));
         chk("sleep_cnt_o",    i, 32'(sleep_cnt_o),    32'(e.cnt));
      end
      fetch = 1'b0;

      // Gated clock runs in RUN.
      @(negedge clk);
      busy = 1'b1;
      base = clko_edges;
      repeat (4) @(posedge clk);
      #1;
      chk("clk_o_run_edges", 100, 32'(clko_edges - base), 32'd4);

      // Busy drop to SLEEP takes 1+IdleDelay edges.
      @(negedge clk);
      busy = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!core_sleep_o && n < 10);
      chk("idle_to_sleep_latency", 101, 32'(n), 32'd3);
      chk("sleep_cnt_after_reset", 102, 32'(sleep_cnt_o), 32'd1);

      // Clock stopped while asleep.
      @(negedge clk);
      base = clko_edges;
      repeat (4) @(posedge clk);
      #1;
      chk("clk_o_sleep_edges", 103, 32'(clko_edges - base), 32'd0);

      // Scan enable forces the gate open but leaves the FSM asleep.
      @(negedge clk);
      test_en = 1'b1;
      base = clko_edges;
      repeat (4) @(posedge clk);
      #1;
      chk("clk_o_test_en_edges", 104, 32'(clko_edges - base), 32'd4);
      chk("test_en_sleep_held", 105, 32'(core_sleep_o), 32'd1);
      chk("test_en_ce_low", 106, 32'(clock_en_o), 32'd0);
      @(negedge clk);
      test_en = 1'b0;

      // Debug wake reaches clock_en after 1+WakeDelay edges.
      @(negedge clk);
      dbg = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!clock_en_o && n < 10);
      chk("wake_latency", 107, 32'(n), 32'd2);
      chk("wake_cause_debug", 108, 32'(wake_cause_o), 32'h20);
      @(negedge clk);
      dbg = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
